// File: rtl/ir_defs.sv
// Shared IR frame definitions: field widths, field slices, scheduler FSM
// encodings and the queued-command record.
package ir_defs;

  localparam int IR_CMD_W   = 7;
  localparam int IR_ADDR_W  = 5;
  localparam int IR_FRAME_W = 12;

  localparam int IR_CMD_LSB  = 0;
  localparam int IR_CMD_MSB  = IR_CMD_W - 1;
  localparam int IR_ADDR_LSB = IR_CMD_W;
  localparam int IR_ADDR_MSB = IR_FRAME_W - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // One queued command: the raw frame plus the auto-repeat marker.
  typedef struct packed {
    logic                  rpt;
    logic [IR_FRAME_W-1:0] frame;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

  function automatic logic [IR_ADDR_W-1:0] frame_addr(input logic [IR_FRAME_W-1:0] f);
    return f[IR_ADDR_MSB:IR_ADDR_LSB];
  endfunction

endpackage

// File: rtl/ir_cmd_sched_if.sv
// Command hand-off channel between the scheduler and its consumers.
interface ir_cmd_sched_if;
  import ir_defs::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [IR_FRAME_W-1:0] cmd;
  logic                  cmd_rpt;

  modport master (output cmd_valid, output cmd, output cmd_rpt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input cmd_rpt, output cmd_ready);

endinterface

// File: rtl/ir_cmd_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot on the same edge; otherwise it is dropped and ovf pulses for
// one cycle. The head reads as zero while empty.
module ir_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and overflow-flag update; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      ovf <= push && full && !pop_ok;
    end
  end

  // Storage write; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ir_cmd_sched.sv
// IR command scheduler: frame edge detect, address filter, press/auto-repeat
// shaping and queued valid/ready hand-off to the command consumers.
module ir_cmd_sched
  import ir_defs::*;
#(
  parameter logic [IR_ADDR_W-1:0] DEV_ADDR    = 5'h01,
  parameter bit                   ACCEPT_ALL  = 1'b0,
  parameter int                   WIN_CYC     = 2_500_000,
  parameter int                   HOLD_FRAMES = 8,
  parameter int                   DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IR_FRAME_W-1:0] ir_data,
  input  logic                  ir_rdy,
  ir_cmd_sched_if.master        cmd_if,
  output logic                  ovf,
  output logic [7:0]            drop_cnt
);

  localparam int TW = $clog2(WIN_CYC + 1);
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(WIN_CYC - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0] HOLD_THR = CW'(HOLD_FRAMES - 1);

  logic                  rdy_p0;
  logic                  evt;
  logic                  addr_ok;
  logic                  acc;
  logic                  same_code;
  logic [0:0]            state;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         rpt_cnt;
  logic [IR_FRAME_W-1:0] last_code;
  logic                  push_p1;
  logic                  rpt_p1;
  logic [IR_FRAME_W-1:0] frame_p1;
  cmd_entry_t            fifo_din;
  cmd_entry_t            head;
  logic                  fifo_empty;

  assign evt       = ir_rdy && !rdy_p0;
  assign addr_ok   = ACCEPT_ALL || (frame_addr(ir_data) == DEV_ADDR);
  assign acc       = evt && addr_ok;
  assign same_code = (state == ST_HELD) && (ir_data == last_code);

  // ---- stage p0: ir_rdy edge detect (starts high so a pending frame at reset release is ignored)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_p0 <= 1'b1;
    else        rdy_p0 <= ir_rdy;
  end

  // Saturating count of frames rejected by the address filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt <= 8'd0;
    else if (evt && !addr_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  // Press/repeat FSM with release timer; an accepted event beats the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      rpt_cnt   <= '0;
      last_code <= '0;
      push_p1   <= 1'b0;
    end else begin
      push_p1 <= 1'b0;
      if (acc) begin
        timer <= '0;
        if (same_code) begin
          if (rpt_cnt != HOLD_MAX) rpt_cnt <= rpt_cnt + 1'b1;
          if (rpt_cnt >= HOLD_THR) push_p1 <= 1'b1;
        end else begin
          push_p1   <= 1'b1;
          last_code <= ir_data;
          rpt_cnt   <= CW'(1);
          state     <= ST_HELD;
        end
      end else if (state == ST_HELD) begin
        if (timer == WIN_LAST) begin
          state   <= ST_IDLE;
          timer   <= '0;
          rpt_cnt <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: payload captured alongside push_p1, written into the FIFO next edge
  always_ff @(posedge clk) begin
    frame_p1 <= ir_data;
    rpt_p1   <= same_code;
  end

  assign fifo_din = '{rpt: rpt_p1, frame: frame_p1};

  ir_cmd_fifo #(
    .WIDTH (CMD_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_p1),
    .din   (fifo_din),
    .pop   (cmd_if.cmd_ready),
    .dout  (head),
    .empty (fifo_empty),
    .ovf   (ovf)
  );

  assign cmd_if.cmd_valid = !fifo_empty;
  assign cmd_if.cmd       = head.frame;
  assign cmd_if.cmd_rpt   = head.rpt;

endmodule

// File: tb/tb_ir_cmd_sched.sv
// Directed bench for ir_cmd_sched with a cycle-level reference model and
// hand-computed expectations for each scenario.
module tb_ir_cmd_sched;

  localparam int WIN_CYC     = 100;
  localparam int HOLD_FRAMES = 3;
  localparam int DEPTH       = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ir_data;
  logic        ir_rdy;
  logic        ovf;
  logic [7:0]  drop_cnt;

  ir_cmd_sched_if cmd_if();

  ir_cmd_sched #(
    .DEV_ADDR    (5'h01),
    .ACCEPT_ALL  (1'b0),
    .WIN_CYC     (WIN_CYC),
    .HOLD_FRAMES (HOLD_FRAMES),
    .DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_data  (ir_data),
    .ir_rdy   (ir_rdy),
    .cmd_if   (cmd_if),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_seen = 0;

  logic [11:0] log_cmd [$];
  logic        log_rpt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [11:0] mq_frame [$];
  logic        mq_rpt   [$];
  bit          pend, pend_rpt, exp_ovf, m_prev, m_held, acc, evt;
  logic [11:0] pend_frame, m_code;
  int          m_drop, m_cnt, m_sil;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq_frame.delete(); mq_rpt.delete();
      pend = 0; exp_ovf = 0; m_prev = 1; m_held = 0; m_code = '0;
      m_drop = 0; m_cnt = 0; m_sil = 0;
      chk("rst_valid", cmd_if.cmd_valid, 0);
      chk("rst_cmd", cmd_if.cmd, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_drop", drop_cnt, 0);
    end else begin
      chk("valid", cmd_if.cmd_valid, (mq_frame.size() > 0));
      if (mq_frame.size() > 0) begin
        chk("cmd", cmd_if.cmd, mq_frame[0]);
        chk("cmd_rpt", cmd_if.cmd_rpt, mq_rpt[0]);
      end
      chk("ovf", ovf, exp_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (ovf) ovf_seen++;
      // what the coming edge does
      if (mq_frame.size() > 0 && cmd_if.cmd_ready) begin
        log_cmd.push_back(cmd_if.cmd);
        log_rpt.push_back(cmd_if.cmd_rpt);
        void'(mq_frame.pop_front());
        void'(mq_rpt.pop_front());
      end
      exp_ovf = 0;
      if (pend) begin
        if (mq_frame.size() < DEPTH) begin
          mq_frame.push_back(pend_frame);
          mq_rpt.push_back(pend_rpt);
        end else exp_ovf = 1;
      end
      pend = 0;
      evt = ir_rdy && !m_prev;
      m_prev = ir_rdy;
      acc = 0;
      if (evt) begin
        if (ir_data[11:7] == 5'h01) begin
          acc = 1;
          m_sil = 0;
          if (m_held && ir_data == m_code) begin
            if (m_cnt >= HOLD_FRAMES - 1) begin
              pend = 1; pend_frame = ir_data; pend_rpt = 1;
            end
            if (m_cnt < HOLD_FRAMES) m_cnt++;
          end else begin
            pend = 1; pend_frame = ir_data; pend_rpt = 0;
            m_code = ir_data; m_cnt = 1; m_held = 1;
          end
        end else if (m_drop < 255) m_drop++;
      end
      if (!acc && m_held) begin
        m_sil++;
        if (m_sil >= WIN_CYC) begin m_held = 0; m_cnt = 0; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [11:0] code, input int hold);
    ir_data = code;
    ir_rdy  = 1'b1;
    tick(hold);
    ir_rdy  = 1'b0;
  endtask

  task automatic clear_log();
    log_cmd.delete();
    log_rpt.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] codes4 [4];
    int ovf0;
    rst_n = 1'b0; ir_rdy = 1'b1; ir_data = 12'h095; cmd_if.cmd_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    // frame pending at reset release must be ignored
    tick(10); ir_rdy = 1'b0; tick(5);
    chk("pending_at_release", log_cmd.size(), 0);

    // 1: single press, latency
    clear_log();
    ir_data = 12'h095; ir_rdy = 1'b1;
    @(negedge clk); chk("t1_pre", cmd_if.cmd_valid, 0);
    @(negedge clk); chk("t1_edge1", cmd_if.cmd_valid, 0);
    @(negedge clk); chk("t1_edge2", cmd_if.cmd_valid, 1);
    chk("t1_cmd", cmd_if.cmd, 12'h095);
    chk("t1_rpt", cmd_if.cmd_rpt, 0);
    @(negedge clk); chk("t1_edge3", cmd_if.cmd_valid, 0);
    tick(17); ir_rdy = 1'b0;
    tick(120);
    chk("t1_count", log_cmd.size(), 1);

    // 2: address filter
    clear_log();
    frame(12'h115, 5); tick(10);
    chk("t2_drop", drop_cnt, 1);
    chk("t2_none", log_cmd.size(), 0);

    // 3: hold / auto-repeat
    clear_log();
    for (int i = 0; i < 6; i++) begin frame(12'h095, 5); tick(45); end
    chk("t3_count", log_cmd.size(), 5);
    if (log_cmd.size() == 5) begin
      chk("t3_rpt0", log_rpt[0], 0);
      for (int i = 1; i < 5; i++) chk($sformatf("t3_rpt%0d", i), log_rpt[i], 1);
      chk("t3_cmd4", log_cmd[4], 12'h095);
    end
    tick(110);
    frame(12'h095, 5); tick(10);
    chk("t3_after_release", log_cmd.size(), 6);
    if (log_cmd.size() == 6) chk("t3_release_rpt", log_rpt[5], 0);

    // 4: backpressure and overflow
    cmd_if.cmd_ready = 1'b0; clear_log(); ovf0 = ovf_seen;
    for (int i = 1; i <= 5; i++) begin frame(12'h080 + 12'(i), 3); tick(7); end
    chk("t4_ovf_pulses", ovf_seen - ovf0, 1);
    chk("t4_valid_held", cmd_if.cmd_valid, 1);
    cmd_if.cmd_ready = 1'b1; tick(10);
    chk("t4_drained", log_cmd.size(), 4);
    if (log_cmd.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t4_order%0d", i), log_cmd[i], 12'h081 + 12'(i));

    // 5: full FIFO, push coincident with pop
    cmd_if.cmd_ready = 1'b0; clear_log();
    for (int i = 1; i <= 4; i++) begin frame(12'h0A0 + 12'(i), 3); tick(7); end
    ovf0 = ovf_seen;
    ir_data = 12'h0A5; ir_rdy = 1'b1;
    tick(1); cmd_if.cmd_ready = 1'b1;
    tick(1); cmd_if.cmd_ready = 1'b0; ir_rdy = 1'b0;
    tick(5);
    chk("t5_no_ovf", ovf_seen - ovf0, 0);
    chk("t5_popped_one", log_cmd.size(), 1);
    cmd_if.cmd_ready = 1'b1; tick(10);
    chk("t5_total", log_cmd.size(), 5);
    codes4 = '{12'h0A2, 12'h0A3, 12'h0A4, 12'h0A5};
    if (log_cmd.size() == 5)
      for (int i = 0; i < 4; i++) chk($sformatf("t5_order%0d", i), log_cmd[i+1], codes4[i]);

    // 6: asynchronous reset mid-operation
    cmd_if.cmd_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin frame(12'h0B0 + 12'(i), 3); tick(7); end
    chk("t6_queued", cmd_if.cmd_valid, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("t6_async_valid", cmd_if.cmd_valid, 0);
    chk("t6_async_drop", drop_cnt, 0);
    tick(3); rst_n = 1'b1; tick(3);
    cmd_if.cmd_ready = 1'b1; clear_log();
    frame(12'h095, 3); tick(10);
    chk("t6_count", log_cmd.size(), 1);
    if (log_cmd.size() == 1) chk("t6_rpt", log_rpt[0], 0);

    // 7: release window boundary (100 edges: still held, 101: released)
    tick(150); clear_log();
    frame(12'h095, 5); tick(95);
    frame(12'h095, 5); tick(96);
    frame(12'h095, 5); tick(10);
    chk("t7_count", log_cmd.size(), 2);
    if (log_cmd.size() == 2) chk("t7_rpt", log_rpt[1], 0);

    // 8: drop counter saturation
    for (int i = 0; i < 260; i++) begin frame(12'h115, 1); tick(1); end
    tick(3);
    chk("t8_drop_sat", drop_cnt, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_cmd_sched.md
# ir_cmd_sched

Command scheduler between `ir_receiver` and the command consumers (`led_mgr`, `command_display`). It performs several steps on each `ir_receiver` frame:
- detects each new frame and filters it by device address;
- turns held-key auto-repeat frames into a controlled press/repeat stream;
- queues accepted commands in a small FIFO;
- hands them out over a valid/ready handshake.

It replaces the ad-hoc edge-detect/latch logic in the top level.

## Interface
Parameters:
- `DEV_ADDR`, 5'h01: accepted device address.
- `ACCEPT_ALL`, 0: 1 disables the address filter.
- `WIN_CYC`, 2_500_000: cycles of frame silence after which a held key counts as released (50 ms at 50 MHz).
- `HOLD_FRAMES`, 8: same-code frames within the window before auto-repeat starts emitting (≥2).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `ir_data`  in  12: frame from `ir_receiver`; [6:0] command, [11:7] address.
- `ir_rdy`  in  1: level, high while `ir_data` is valid.
- `cmd_valid`  out  1: FIFO head valid.
- `cmd_ready`  in  1: consumer accepts head.
- `cmd`  out  12: head frame (address + command).
- `cmd_rpt`  out  1: head is an auto-repeat, not an initial press.
- `ovf`  out  1: one-cycle pulse, an accepted command was dropped because the FIFO was full.
- `drop_cnt`  out  8: saturating count of address-filtered frames.

## Operation
- Reset values:
  - `cmd_valid`=0, `cmd`=0, `cmd_rpt`=0, `ovf`=0, `drop_cnt`=0.
  - FIFO empty, state IDLE, timer 0, repeat counter 0, last code 0.
  - The registered previous `ir_rdy` sample is 1, so a frame already pending at reset release is ignored.
- Frame event: `ir_rdy`=1 and the previous registered sample = 0. Exactly one event per rising edge, however long `ir_rdy` stays high.
- Address filter:
  - An event with address ≠ `DEV_ADDR` and `ACCEPT_ALL`=0 is discarded.
  - It increments `drop_cnt`, saturating at 255.
  - It does not touch the timer or the state.
- FSM, two states:
  - IDLE, on accepted event:
    - push {frame, rpt=0};
    - store the code;
    - repeat counter = 1;
    - timer = 0;
    - go to HELD.
  - HELD, on accepted event with the same 12-bit code:
    - timer = 0;
    - repeat counter increments, saturating at `HOLD_FRAMES`;
    - if the counter before the increment is ≥ `HOLD_FRAMES`-1, push {frame, rpt=1}; otherwise no push.
  - HELD, on accepted event with a different code: treat as a new press. Push with rpt=0, store the code, counter = 1, timer = 0, stay in HELD.
  - HELD, no event: the timer increments. When it reaches `WIN_CYC`, go to IDLE (counter 0). An event in that same cycle takes priority and is handled as HELD.
- FIFO:
  - Push when full: the push is dropped and `ovf` pulses, unless `cmd_ready`&&`cmd_valid` in the same cycle. In that case the pop frees the slot and the push succeeds.
  - Push and pop together when not full: both occur.
  - No bypass: an empty FIFO takes one cycle to present data.
  - Pointers are `$clog2(DEPTH)`+1 bits and wrap naturally. Full = MSBs differ and the rest are equal.
- `cmd`/`cmd_rpt` are stable while `cmd_valid`=1 and `cmd_ready`=0.
- Asynchronous reset mid-operation flushes the FIFO and the FSM immediately. No partial state survives.

## Timing
- Posedge k samples the `ir_rdy` rising edge → FIFO write at posedge k+1 → `cmd_valid`=1 after posedge k+1, when the FIFO was empty.
- Pop at a posedge where `cmd_valid`&&`cmd_ready`. The next entry (if any) is presented after that same edge. Throughput is one command per cycle.
- `ovf` is high for exactly the cycle after the dropped-write edge.
- Release detection: IDLE is entered `WIN_CYC` cycles after the last accepted event.

## Structure
- Shared package `ir_defs` holds:
  - `IR_CMD_W`=7, `IR_ADDR_W`=5, `IR_FRAME_W`=12;
  - the field slice constants;
  - FSM state encodings `ST_IDLE`, `ST_HELD`.
  
  `ir_receiver` and `led_mgr` use the same package.
- Sub-module `ir_cmd_fifo`: parameterised (`WIDTH`=13, `DEPTH`) synchronous FIFO with push/pop/full/empty/ovf.
- Top-level edge-detect logic is removed. `led_mgr` receives `new_cmd` = `cmd_valid` and ties `cmd_ready`=1.

## Test plan
Test parameters: `WIN_CYC`=100, `HOLD_FRAMES`=3, `DEPTH`=4, `DEV_ADDR`=5'h01.

1. Single press:
   - Stimulus: `ir_data`=12'h095 (addr 1, cmd 0x15), `ir_rdy` high for 20 cycles, `cmd_ready`=1.
   - Response: one `cmd_valid` pulse, `cmd`=12'h095, `cmd_rpt`=0, exactly 2 edges after the `ir_rdy` rise.
2. Address filter: frame 12'h115 (addr 2). No `cmd_valid`; `drop_cnt`=1; the FSM stays IDLE.
3. Hold:
   - Stimulus: 6 frames of 12'h095 spaced 50 cycles apart.
   - Response: outputs with rpt 0, (none), 1, 1, 1, 1, i.e. 5 commands in total.
   - After 100 idle cycles a new 12'h095 gives rpt=0.
4. Backpressure:
   - Stimulus: `cmd_ready`=0, five distinct codes spaced 10 cycles apart.
   - Response: first four queued; fifth drops with one `ovf` pulse.
   - Raising `cmd_ready` drains the four codes in order.
5. Full plus simultaneous pop: with the FIFO full, push coincident with `cmd_ready`=1. No `ovf`; occupancy stays 4.
6. Reset mid-operation: assert `rst_n`=0 with 3 entries queued and state HELD. `cmd_valid` drops asynchronously; after release, a new press yields rpt=0.
